// File: rtl/xorshift_stream_gen.sv
// Xorshift pseudo-random stream generator: emits a run of len successive
// xorshift values from a seed over a valid/ready stream, with abort and done.
module xorshift_stream_gen #(
    parameter int WIDTH = 32,
    parameter int SH_A  = 13,
    parameter int SH_B  = 17,
    parameter int SH_C  = 5,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] seed,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rand_num,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, GEN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rand_q, rand_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] start_state;
    logic             fire;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] t;
        t = x ^ (x << SH_A);
        t = t ^ (t >> SH_B);
        return t ^ (t << SH_C);
    endfunction

    // An all-zero state is a fixed point of xorshift, so it is replaced by 1.
    assign start_state = (seed == '0) ? WIDTH'(1) : seed;

    assign out_valid = (state_q == GEN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign rand_num  = rand_q;
    assign fire      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        rand_d  = rand_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (len != '0) begin
                        state_d = GEN;
                        rand_d  = step(start_state);
                        cnt_d   = len;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            GEN: begin
                if (fire) begin
                    rand_d = step(rand_q);
                    cnt_d  = cnt_q - LEN_W'(1);
                end
                // Abort wins over completion: the run ends without a done pulse.
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (fire && cnt_q == LEN_W'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rand_q  <= rand_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xorshift_stream_gen.sv
// Bench for xorshift_stream_gen: a 32-bit and a 64-bit instance share one
// stimulus stream and are each checked every cycle against a run-level model.
module tb_xorshift_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] seed;
    logic [15:0] len;
    logic        abort;
    logic        out_ready;

    logic        valid32, busy32, done32;
    logic [31:0] rand32;
    logic        valid64, busy64, done64;
    logic [63:0] rand64;

    int total = 0;
    int bad   = 0;

    // Model state per instance: index 0 is the 32-bit generator, 1 the 64-bit one.
    logic        m_valid [2];
    logic        m_busy  [2];
    logic        m_done  [2];
    logic        m_known [2];
    logic [63:0] m_word  [2];
    int          m_rem   [2];

    always #5 clk = ~clk;

    xorshift_stream_gen #(.WIDTH(32), .SH_A(13), .SH_B(17), .SH_C(5), .LEN_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .seed(seed[31:0]), .len(len),
        .abort(abort), .out_ready(out_ready), .out_valid(valid32), .rand_num(rand32),
        .busy(busy32), .done(done32)
    );

    xorshift_stream_gen #(.WIDTH(64), .SH_A(13), .SH_B(7), .SH_C(17), .LEN_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .seed(seed), .len(len),
        .abort(abort), .out_ready(out_ready), .out_valid(valid64), .rand_num(rand64),
        .busy(busy64), .done(done64)
    );

    function automatic logic [63:0] step(input int w, input logic [63:0] x);
        logic [31:0] a;
        logic [63:0] b;
        if (w == 32) begin
            a = x[31:0];
            a = a ^ (a << 13);
            a = a ^ (a >> 17);
            a = a ^ (a << 5);
            return {32'h0, a};
        end
        b = x;
        b = b ^ (b << 13);
        b = b ^ (b >> 7);
        b = b ^ (b << 17);
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One call is one clock cycle: inputs change on the falling edge.
    task automatic applyStimulus(input logic iv, input logic [63:0] sd, input logic [15:0] ln,
                                 input logic ab, input logic rdy, input logic rn);
        @(negedge clk);
        in_valid  = iv;
        seed      = sd;
        len       = ln;
        abort     = ab;
        out_ready = rdy;
        rst_n     = rn;
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, rdy, 1'b1);
    endtask

    // Run-level reference: a run is "emitting" with a remaining word count,
    // followed by a one-cycle done phase unless aborted.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int          w;
            logic [63:0] s0;
            w = (i == 0) ? 32 : 64;
            if (!rst_n) begin
                m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
                m_word[i]  = 64'h0; m_rem[i]  = 0;    m_known[i] = 1'b1;
            end else if (m_done[i]) begin
                m_done[i] = 1'b0;
                m_busy[i] = 1'b0;
            end else if (m_valid[i]) begin
                if (out_ready) begin
                    m_rem[i]  = m_rem[i] - 1;
                    m_word[i] = step(w, m_word[i]);
                end
                if (abort) begin
                    m_valid[i] = 1'b0; m_busy[i] = 1'b0; m_known[i] = 1'b0;
                end else if (out_ready && m_rem[i] == 0) begin
                    m_valid[i] = 1'b0; m_done[i] = 1'b1; m_known[i] = 1'b0;
                end
            end else if (in_valid) begin
                if (len != 16'h0) begin
                    s0 = (i == 0) ? {32'h0, seed[31:0]} : seed;
                    if (s0 == 64'h0) s0 = 64'h1;
                    m_word[i]  = step(w, s0);
                    m_rem[i]   = int'(len);
                    m_valid[i] = 1'b1; m_busy[i] = 1'b1; m_known[i] = 1'b1;
                end else begin
                    m_done[i] = 1'b1;
                    m_busy[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("valid32", {63'h0, valid32}, {63'h0, m_valid[0]});
            checkOutput("busy32",  {63'h0, busy32},  {63'h0, m_busy[0]});
            checkOutput("done32",  {63'h0, done32},  {63'h0, m_done[0]});
            if (m_known[0]) checkOutput("rand32", {32'h0, rand32}, m_word[0]);
            checkOutput("valid64", {63'h0, valid64}, {63'h0, m_valid[1]});
            checkOutput("busy64",  {63'h0, busy64},  {63'h0, m_busy[1]});
            checkOutput("done64",  {63'h0, done64},  {63'h0, m_done[1]});
            if (m_known[1]) checkOutput("rand64", rand64, m_word[1]);
        end
    end

    initial begin
        logic rdy_pat [7];
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; seed = 64'h0; len = 16'h0; abort = 1'b0; out_ready = 1'b1;

        checkOutput("model_step32_a", step(32, 64'h1), 64'h0000_0000_0004_2021);
        checkOutput("model_step32_b", step(32, 64'h42021), 64'h0000_0000_0408_0601);
        checkOutput("model_step64_a", step(64, 64'h1), 64'h0000_0000_4082_2041);

        applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("reset_rand32", {32'h0, rand32}, 64'h0);
        idleCycles(2, 1'b1);

        $display("[TB] basic run, seed=1 len=3");
        applyStimulus(1'b1, 64'h1, 16'd3, 1'b0, 1'b1, 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("t1_word1_32", {32'h0, rand32}, 64'h0004_2021);
        checkOutput("t1_word1_64", rand64, 64'h4082_2041);
        idleCycles(1, 1'b1);
        checkOutput("t1_word2_32", {32'h0, rand32}, 64'h0408_0601);
        idleCycles(4, 1'b1);

        $display("[TB] zero seed, len=1");
        applyStimulus(1'b1, 64'h0, 16'd1, 1'b0, 1'b1, 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("t2_word_32", {32'h0, rand32}, 64'h0004_2021);
        checkOutput("t2_word_64", rand64, 64'h4082_2041);
        idleCycles(3, 1'b1);

        $display("[TB] backpressure, seed=1 len=4");
        applyStimulus(1'b1, 64'h1, 16'd4, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, rdy_pat[k], 1'b1);
            if (k == 2) checkOutput("t3_held_32", {32'h0, rand32}, 64'h0408_0601);
        end
        idleCycles(4, 1'b1);

        $display("[TB] zero length run");
        applyStimulus(1'b1, 64'h1234, 16'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h1, 16'd2, 1'b0, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        $display("[TB] abort with the 11th transfer");
        applyStimulus(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 16'd100, 1'b0, 1'b1, 1'b1);
        idleCycles(10, 1'b1);
        applyStimulus(1'b1, 64'h77, 16'd5, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h9999, 16'd3, 1'b0, 1'b1, 1'b1);
        idleCycles(6, 1'b1);

        $display("[TB] reset mid-run, then restart");
        applyStimulus(1'b1, 64'h5555, 16'd50, 1'b0, 1'b1, 1'b1);
        idleCycles(5, 1'b1);
        applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'h1, 16'd2, 1'b0, 1'b1, 1'b1);
        checkOutput("t6_reset_rand64", rand64, 64'h0);
        idleCycles(1, 1'b1);
        checkOutput("t6_restart_32", {32'h0, rand32}, 64'h0004_2021);
        idleCycles(4, 1'b1);

        $display("[TB] 64-bit seed with zero low half");
        applyStimulus(1'b1, 64'h1_0000_0000, 16'd2, 1'b0, 1'b1, 1'b1);
        idleCycles(4, 1'b1);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 2000; k++) begin
            logic [63:0] sd;
            sd = ($urandom % 8 == 0) ? 64'h0 : {$urandom, $urandom};
            applyStimulus(($urandom % 4) == 0, sd, 16'($urandom % 7),
                          ($urandom % 25) == 0, ($urandom % 3) != 0,
                          ($urandom % 300) != 0);
        end
        idleCycles(10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xorshift_stream_gen.md
Name: xorshift_stream_gen

Overview:
Parametrised xorshift pseudo-random stream generator. It accepts a seed and a run length, then emits exactly that many successive xorshift values over a valid/ready stream into the downstream async FIFO write side. Compared with the fixed 32-bit, 256-word generator, it adds configurable width and shift triplet, a runtime length, abort, a done pulse, zero-seed protection, and hold-under-backpressure semantics.

Parameters:
WIDTH, 32, data/state width in bits (32 or 64 supported)
SH_A, 13, first left-shift amount
SH_B, 17, right-shift amount
SH_C, 5, second left-shift amount
LEN_W, 16, width of the run-length input and internal counter

Ports:
clk  input  1  single clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  start request; seed and len sampled when accepted
seed  input  WIDTH  initial state
len  input  LEN_W  number of words to emit in this run
abort  input  1  terminate the current run
out_ready  input  1  downstream can accept (equals !fifo_full)
out_valid  output  1  rand_num is valid
rand_num  output  WIDTH  current random word
busy  output  1  run in progress; in_valid is ignored while high
done  output  1  one-cycle pulse after the last word transfers

Behaviour:
- One clock. Reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset state: IDLE. out_valid=0, rand_num=0, busy=0, done=0, counter=0. Reset mid-run discards the run; no done pulse.
- Step function f(x), computed at WIDTH bits with bits shifted out discarded:
  - t = x ^ (x << SH_A)
  - t = t ^ (t >> SH_B)
  - f = t ^ (t << SH_C)
- FSM states: IDLE, GEN, FIN.
- IDLE:
  - busy=0.
  - in_valid=1 with len!=0: next state GEN, rand_num <= f(s0), counter <= len. s0 = seed, or s0 = 1 when seed==0 (lock-up protection).
  - in_valid=1 with len==0: next state FIN, no word emitted.
  - abort in IDLE has no effect.
- GEN:
  - out_valid=1 and busy=1, both registered.
  - First word is visible the cycle after acceptance, so latency is 1 cycle.
  - Transfer occurs when out_valid && out_ready at a clock edge.
  - On a transfer: counter decrements and rand_num <= f(rand_num).
  - On a transfer when counter==1: next state FIN, out_valid <= 0.
  - out_ready=0: rand_num and counter hold; the value never advances without a transfer.
  - abort=1: next state IDLE, out_valid <= 0, no done. If a transfer coincides with abort, that word counts as delivered, but the run still ends.
  - abort has priority over last-word completion.
  - in_valid is ignored throughout GEN.
- FIN:
  - done=1 for exactly one cycle, busy=1, out_valid=0.
  - Next state IDLE unconditionally.
  - in_valid during FIN is ignored. The earliest new accept is the cycle after FIN.
- rand_num:
  - Holds its last value when out_valid=0; it is not forced to zero.
  - Consumers must qualify it with out_valid.
- Counter: LEN_W bits, no wrap. Maximum run is 2^LEN_W-1 words.
- Throughput: one word per cycle while out_ready=1.

Test Plan:
1. WIDTH=32, default shifts, seed=1, len=3, out_ready=1 -> out_valid high for exactly 3 cycles starting 1 cycle after accept. First word 0x00042021, second 0x04080601. done pulses 1 cycle after the last word, then busy drops.
2. seed=0, len=1 -> single word 0x00042021 (zero seed substituted by 1), then done.
3. seed=1, len=4, out_ready toggled 1,0,0,1,1,0,1 -> no duplicated or skipped values. The second word 0x04080601 is held through both stall cycles. Exactly 4 transfers.
4. len=0 -> out_valid never asserts; done pulses the cycle after accept; busy high for 1 cycle.
5. len=100, abort asserted after the 10th transfer, together with the 11th transfer -> 11 words delivered, out_valid low next cycle, no done. A new in_valid is accepted the following cycle with the new seed.
6. rst_n low mid-GEN for 1 cycle -> next cycle all outputs at reset values. A later start with seed=1 restarts at 0x00042021. Repeat tests 1 and 3 with WIDTH=64, SH=(13,7,17) against a reference model.
